// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side pointer, level and flag controller
// Optional overflow attempt counter enabled by defining FIFO_WR_OVF_CNT_EN.
module fifo_wr_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray_sync,
    input  logic [ADDR_SIZE:0]   af_thresh,
    input  logic                 ovf_clr,
    output logic                 wr_ack,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_ptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   wr_level,
    output logic                 overflow,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] wr_bin_q,  wr_bin_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic [PW-1:0] level_q,   level_d;
    logic          full_q,    full_d;
    logic          af_q,      af_d;
    logic          ovf_q,     ovf_d;
    logic [PW-1:0] rd_bin_sync;
    logic          ovf_attempt;

    // Gating with wr_rst keeps the RAM strobe quiet while reset is held.
    assign wr_ack      = wr_en & ~full_q & wr_rst;
    assign ovf_attempt = wr_en & full_q;

    always_comb begin
        rd_bin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            rd_bin_sync[i] = ^(rd_ptr_gray_sync >> i);
        end
    end

    always_comb begin
        wr_bin_d  = wr_bin_q + {{ADDR_SIZE{1'b0}}, wr_ack};
        wr_gray_d = (wr_bin_d >> 1) ^ wr_bin_d;
        level_d   = wr_bin_d - rd_bin_sync;
        // Full when the next Gray pointer is exactly one lap ahead of the read pointer.
        full_d    = (wr_gray_d[ADDR_SIZE]   != rd_ptr_gray_sync[ADDR_SIZE]) &
                    (wr_gray_d[ADDR_SIZE-1] != rd_ptr_gray_sync[ADDR_SIZE-1]) &
                    (wr_gray_d[ADDR_SIZE-2:0] == rd_ptr_gray_sync[ADDR_SIZE-2:0]);
        af_d      = (level_d >= af_thresh);
        ovf_d     = ovf_attempt | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            af_q      <= af_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef FIFO_WR_OVF_CNT_EN
    localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = {{(OVF_CNT_W-1){1'b0}}, ovf_attempt};
        end else if (ovf_attempt && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = '0;
`endif

    assign wr_addr     = wr_bin_q[ADDR_SIZE-1:0];
    assign wr_ptr_gray = wr_gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl (ADDR_SIZE=4)
module tb_fifo_wr_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_en;
    logic [4:0] rd_ptr_gray_sync;
    logic [4:0] af_thresh;
    logic       ovf_clr;
    logic       wr_ack;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;
    logic [7:0] ovf_count;

    fifo_wr_ctrl #(.ADDR_SIZE(4), .OVF_CNT_W(8)) dut (
        .wr_clk           (wr_clk),
        .wr_rst           (wr_rst),
        .wr_en            (wr_en),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .af_thresh        (af_thresh),
        .ovf_clr          (ovf_clr),
        .wr_ack           (wr_ack),
        .wr_addr          (wr_addr),
        .wr_ptr_gray      (wr_ptr_gray),
        .full             (full),
        .almost_full      (almost_full),
        .wr_level         (wr_level),
        .overflow         (overflow),
        .ovf_count        (ovf_count)
    );

    always #5 wr_clk = ~wr_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: total writes and reads as plain integers.
    int wr_cnt, rd_cnt, m_level, m_cnt;
    bit m_full, m_af, m_ovf;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wr_cnt = 0; rd_cnt = 0; m_level = 0; m_cnt = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".addr"},  {28'd0, wr_addr},     32'(wr_cnt % 16));
        chk({tag, ".gray"},  {27'd0, wr_ptr_gray}, {27'd0, gray5(wr_cnt)});
        chk({tag, ".full"},  {31'd0, full},        {31'd0, m_full});
        chk({tag, ".af"},    {31'd0, almost_full}, {31'd0, m_af});
        chk({tag, ".level"}, {27'd0, wr_level},    32'(m_level));
        chk({tag, ".ovf"},   {31'd0, overflow},    {31'd0, m_ovf});
`ifdef FIFO_WR_OVF_CNT_EN
        chk({tag, ".cnt"},   {24'd0, ovf_count},   32'(m_cnt));
`else
        chk({tag, ".cnt"},   {24'd0, ovf_count},   32'd0);
`endif
    endtask

    task automatic step(input string tag, input bit wen, input int rd_t, input bit clr);
        bit attempt;
        @(negedge wr_clk);
        wr_en            = wen;
        rd_cnt           = rd_t;
        rd_ptr_gray_sync = gray5(rd_t);
        ovf_clr          = clr;
        #1;
        chk({tag, ".ack"}, {31'd0, wr_ack}, {31'd0, (wen && !m_full)});
        @(posedge wr_clk);
        attempt = wen && m_full;
        if (wen && !m_full) wr_cnt++;
        m_ovf = attempt || (m_ovf && !clr);
        if (clr) m_cnt = attempt ? 1 : 0;
        else if (attempt && m_cnt < 255) m_cnt++;
        m_level = wr_cnt - rd_cnt;
        m_full  = (m_level == 16);
        m_af    = (m_level >= int'(af_thresh));
        #1;
        chk_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        #2 wr_rst = 1'b0;
        #1;
        model_reset();
        chk("rst.ack", {31'd0, wr_ack}, 32'd0);
        chk_outputs("rst");
        @(negedge wr_clk);
        wr_en = 1'b0; ovf_clr = 1'b0; rd_ptr_gray_sync = '0;
        wr_rst = 1'b1;
    endtask

    initial begin
        int rd_t;
        wr_rst = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0;
        rd_ptr_gray_sync = '0; af_thresh = 5'd12;
        model_reset();
        #3;
        chk("por.ack", {31'd0, wr_ack}, 32'd0);
        chk_outputs("por");
        @(negedge wr_clk);
        wr_rst = 1'b1;

        // 16 back-to-back writes fill the FIFO
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 0, 1'b0);
        chk("fill.full_c",  {31'd0, full},        32'd1);
        chk("fill.gray_c",  {27'd0, wr_ptr_gray}, 32'b11000);
        chk("fill.level_c", {27'd0, wr_level},    32'd16);
        chk("fill.addr_c",  {28'd0, wr_addr},     32'd0);

        // overflow set, clear, and set-wins-over-clear
        step("ovf1", 1'b1, 0, 1'b0);
        chk("ovf1.ovf_c", {31'd0, overflow}, 32'd1);
        step("ovfclr", 1'b0, 0, 1'b1);
        chk("ovfclr.ovf_c", {31'd0, overflow}, 32'd0);
        step("ovfboth", 1'b1, 0, 1'b1);
        chk("ovfboth.ovf_c", {31'd0, overflow}, 32'd1);
        step("ovf3", 1'b1, 0, 1'b0);
        step("ovf4", 1'b1, 0, 1'b0);

        // almost-full threshold from empty
        do_reset();
        af_thresh = 5'd12;
        for (int i = 1; i <= 12; i++) begin
            step("af", 1'b1, 0, 1'b0);
            if (i == 11) chk("af.l11", {31'd0, almost_full}, 32'd0);
            if (i == 12) chk("af.l12", {31'd0, almost_full}, 32'd1);
        end
        for (int i = 0; i < 4; i++) step("af.fill", 1'b1, 0, 1'b0);

        // read pointer jumps to 4 while full
        step("rdadv", 1'b0, 4, 1'b0);
        chk("rdadv.full_c",  {31'd0, full},     32'd0);
        chk("rdadv.level_c", {27'd0, wr_level}, 32'd12);
        step("resume", 1'b1, 4, 1'b0);

        do_reset();
        af_thresh = 5'd0;
        step("af0", 1'b0, 0, 1'b0);
        chk("af0.c", {31'd0, almost_full}, 32'd1);
        af_thresh = 5'd20;

        // 40 writes with the read side trailing, pointer wraps
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step("wrap", 1'b1, (wr_cnt >= 1) ? wr_cnt - 1 : 0, 1'b0);
            if (i >= 1) chk("wrap.level_c", {27'd0, wr_level}, 32'd2);
        end
        chk("wrap.full_c", {31'd0, full}, 32'd0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) af_thresh = 5'($urandom_range(0, 18));
            rd_t = rd_cnt;
            if (wr_cnt > rd_cnt) rd_t += $urandom_range(0, (wr_cnt - rd_cnt > 3) ? 3 : wr_cnt - rd_cnt);
            if (i % 100 > 70) rd_t = rd_cnt;
            step("rnd", ($urandom % 4) != 0, rd_t, ($urandom % 8) == 0);
        end

`ifdef FIFO_WR_OVF_CNT_EN
        do_reset();
        for (int i = 0; i < 16; i++) step("cfill", 1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) step("c3", 1'b1, 0, 1'b0);
        chk("c3.cnt_c", {24'd0, ovf_count}, 32'd3);
        for (int i = 0; i < 256 + 5 - 3; i++) step("csat", 1'b1, 0, 1'b0);
        chk("csat.cnt_c", {24'd0, ovf_count}, 32'd255);
        step("cclr", 1'b1, 0, 1'b1);
        chk("cclr.cnt_c", {24'd0, ovf_count}, 32'd1);
`endif

        // async reset mid-burst while full
        do_reset();
        for (int i = 0; i < 18; i++) step("burst", 1'b1, 0, 1'b0);
        wr_en = 1'b1;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
